// File: rtl/spmv_row_mac.sv
// spmv_row_mac: per-channel SpMV multiply-accumulate stage.
// Accepts a CSR element stream, looks up x[col] in vec_file through
// col_idx_out/col_val_in, multiplies, accumulates per row and queues one
// {row, sum} result per row in a small FIFO.
// Optional feature macro: SPMV_MAC_SAT_EN (signed-saturating product and
// accumulate; wrapping arithmetic when undefined).
// DIM_W normally comes from dcp_mock.svh; a fallback keeps this file standalone.
`ifndef DIM_W
`define DIM_W 16
`endif

module spmv_row_mac #(
  parameter int DATA_W    = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spmv_init,
  input  logic               prefetch_done,
  input  logic               elem_val,
  output logic               elem_rdy,
  input  logic [DATA_W-1:0]  elem_mat,
  input  logic [`DIM_W-1:0]  elem_col,
  input  logic [`DIM_W-1:0]  elem_row,
  input  logic               elem_last,
  input  logic               elem_empty,
  output logic [`DIM_W-1:0]  col_idx_out,
  input  logic [DATA_W-1:0]  col_val_in,
  output logic               res_val,
  input  logic               res_rdy,
  output logic [`DIM_W-1:0]  res_row,
  output logic [DATA_W-1:0]  res_data,
  output logic               busy
);

  localparam int DIM_W = `DIM_W;
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Producers must not make valid depend on ready; elem_rdy itself depends
  // only on prefetch_done, reset and the output credit count.

  logic clear;
  assign clear = rst | spmv_init;

  // S1: element accepted, waiting for the vec_file lookup
  logic              s1_v, s1_last, s1_empty;
  logic [DATA_W-1:0] s1_mat;
  logic [DIM_W-1:0]  s1_row, col_q;
  // S2: product ready for accumulation
  logic              s2_v, s2_last;
  logic [DATA_W-1:0] s2_prod;
  logic [DIM_W-1:0]  s2_row;
  logic [DATA_W-1:0] acc;

  // Result FIFO
  logic [DIM_W-1:0]  mem_row  [OUT_DEPTH];
  logic [DATA_W-1:0] mem_data [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;

  logic              accept, push, pop;
  logic [1:0]        lasts_in_flight;
  logic [CNT_W:0]    occupancy;
  logic [DATA_W-1:0] prod, acc_sum;

  // Output credits: rows already queued plus rows still in the pipeline
  always_comb begin
    lasts_in_flight = {1'b0, s1_v & s1_last} + {1'b0, s2_v & s2_last};
    occupancy       = {1'b0, cnt} + (CNT_W+1)'(lasts_in_flight);
    elem_rdy        = prefetch_done && !clear &&
                      (occupancy < (CNT_W+1)'(OUT_DEPTH));
  end

  assign accept      = elem_val && elem_rdy;
  assign push        = s2_v && s2_last;
  assign pop         = res_val && res_rdy;
  assign col_idx_out = col_q;

`ifdef SPMV_MAC_SAT_EN
  localparam logic signed [2*DATA_W-1:0] PROD_MAX =
    {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] PROD_MIN =
    {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [2*DATA_W-1:0] full_prod;
  logic [DATA_W:0]            sum_ext;

  // S1 multiply, clamped to the signed DATA_W range; empty rows give 0
  always_comb begin
    full_prod = $signed({{DATA_W{s1_mat[DATA_W-1]}}, s1_mat}) *
                $signed({{DATA_W{col_val_in[DATA_W-1]}}, col_val_in});
    if (s1_empty)              prod = '0;
    else if (full_prod > PROD_MAX) prod = SAT_MAX;
    else if (full_prod < PROD_MIN) prod = SAT_MIN;
    else                       prod = full_prod[DATA_W-1:0];
  end

  // S2 accumulate, clamped on signed overflow
  always_comb begin
    sum_ext = {acc[DATA_W-1], acc} + {s2_prod[DATA_W-1], s2_prod};
    if (sum_ext[DATA_W] != sum_ext[DATA_W-1])
      acc_sum = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
    else
      acc_sum = sum_ext[DATA_W-1:0];
  end
`else
  // S1 multiply, low DATA_W bits of the two's complement product
  always_comb begin
    prod = s1_empty ? '0 : s1_mat * col_val_in;
  end

  // S2 accumulate, wrapping
  always_comb begin
    acc_sum = acc + s2_prod;
  end
`endif

  // Pipeline registers, accumulator and the held lookup index
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_v     <= 1'b0;
      s1_last  <= 1'b0;
      s1_empty <= 1'b0;
      s1_mat   <= '0;
      s1_row   <= '0;
      col_q    <= '0;
      s2_v     <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
      s2_row   <= '0;
      acc      <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_last  <= elem_last;
        s1_empty <= elem_empty;
        s1_mat   <= elem_mat;
        s1_row   <= elem_row;
        if (!elem_empty) col_q <= elem_col;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_last <= s1_last;
        s2_prod <= prod;
        s2_row  <= s1_row;
      end
      if (s2_v) acc <= s2_last ? '0 : acc_sum;
    end
  end

  // FIFO storage: the completed row sum goes in with its row index
  always_ff @(posedge clk) begin
    if (!clear && push) begin
      mem_row[wr_ptr]  <= s2_row;
      mem_data[wr_ptr] <= acc_sum;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head-of-FIFO presentation, zero when nothing is queued
  always_comb begin
    res_val  = (cnt != '0);
    res_row  = res_val ? mem_row[rd_ptr]  : '0;
    res_data = res_val ? mem_data[rd_ptr] : '0;
    busy     = s1_v | s2_v | res_val;
  end

endmodule

// File: tb/tb_spmv_row_mac.sv
// tb_spmv_row_mac: directed bench for spmv_row_mac with a vec_file model,
// a row-sum model and a result scoreboard.
`ifndef DIM_W
`define DIM_W 16
`endif

module tb_spmv_row_mac;

  localparam int DATA_W    = 32;
  localparam int OUT_DEPTH = 4;
  localparam int DW        = `DIM_W;
  localparam int EW        = DW + DATA_W;
`ifdef SPMV_MAC_SAT_EN
  localparam logic [DATA_W-1:0] BIG_EXP = 32'h7FFFFFFF;
`else
  localparam logic [DATA_W-1:0] BIG_EXP = 32'h00000000;
`endif

  logic              clk, rst, spmv_init, prefetch_done;
  logic              elem_val, elem_rdy, elem_last, elem_empty;
  logic [DATA_W-1:0] elem_mat, col_val_in, res_data;
  logic [DW-1:0]     elem_col, elem_row, col_idx_out, res_row;
  logic              res_val, res_rdy, busy;

  logic [DATA_W-1:0] x_mem [16];
  logic [EW-1:0]     exp_q [$];
  logic [DATA_W-1:0] tb_acc;
  int checks   = 0;
  int failures = 0;

  spmv_row_mac #(.DATA_W(DATA_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst), .spmv_init(spmv_init), .prefetch_done(prefetch_done),
    .elem_val(elem_val), .elem_rdy(elem_rdy), .elem_mat(elem_mat),
    .elem_col(elem_col), .elem_row(elem_row), .elem_last(elem_last),
    .elem_empty(elem_empty), .col_idx_out(col_idx_out), .col_val_in(col_val_in),
    .res_val(res_val), .res_rdy(res_rdy), .res_row(res_row),
    .res_data(res_data), .busy(busy)
  );

  // Clock and vec_file model (combinational same-cycle return)
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign col_val_in = x_mem[col_idx_out[3:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SPMV_MAC_SAT_EN
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (p > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (p < -64'sd2147483648) return 32'h80000000;
    return p[DATA_W-1:0];
`else
    return a * b;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] model_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SPMV_MAC_SAT_EN
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
    return s[DATA_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Row-sum model: on the last element of a row, queue the expected result
  task automatic model_elem(input logic [DATA_W-1:0] mat, input logic [DW-1:0] col,
                            input logic [DW-1:0] row, input logic last, input logic empty);
    logic [DATA_W-1:0] p;
    p = empty ? '0 : model_mul(mat, x_mem[col[3:0]]);
    tb_acc = model_add(tb_acc, p);
    if (last) begin
      exp_q.push_back({row, tb_acc});
      tb_acc = '0;
    end
  endtask

  task automatic drive(input logic [DATA_W-1:0] mat, input logic [DW-1:0] col,
                       input logic [DW-1:0] row, input logic last, input logic empty);
    elem_val = 1'b1; elem_mat = mat; elem_col = col;
    elem_row = row;  elem_last = last; elem_empty = empty;
  endtask

  // Send one element; returns 1 ns after the accepting edge
  task automatic send(input logic [DATA_W-1:0] mat, input logic [DW-1:0] col,
                      input logic [DW-1:0] row, input logic last, input logic empty,
                      input bit use_model = 1'b1);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    drive(mat, col, row, last, empty);
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = elem_rdy;
      if (ok && use_model) model_elem(mat, col, row, last, empty);
      @(posedge clk); #1;
      n++;
    end
    check("send_accepted", 64'(ok), 64'd1);
    elem_val = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard: compare each transferred result with the queue head
  always @(negedge clk) begin
    if (res_val && res_rdy) begin
      if (exp_q.size() == 0) begin
        check("result_without_expectation", 64'(res_val), 64'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("res_row", 64'(res_row), 64'(e[EW-1:DATA_W]));
        check("res_data", 64'(res_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k;
    for (int i = 0; i < 16; i++) x_mem[i] = DATA_W'(i * 3 + 2);
    x_mem[1] = 32'd10; x_mem[4] = 32'd7; x_mem[7] = 32'd4;
    tb_acc = '0;
    rst = 1'b1; spmv_init = 1'b0; prefetch_done = 1'b0; res_rdy = 1'b1;
    elem_val = 1'b0; elem_mat = '0; elem_col = '0; elem_row = '0;
    elem_last = 1'b0; elem_empty = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_elem_rdy", 64'(elem_rdy), 64'd0);
    check("rst_res_val", 64'(res_val), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_col_idx", 64'(col_idx_out), 64'd0);
    check("rst_res_row", 64'(res_row), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    @(posedge clk); #1;

    // Held off by prefetch_done, then row 5 = 2*x[1] + 3*x[4] = 41
    drive(32'd2, DW'(1), DW'(5), 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("no_prefetch_rdy", 64'(elem_rdy), 64'd0);
      check("no_prefetch_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    prefetch_done = 1'b1;
    @(negedge clk);
    check("prefetch_rdy", 64'(elem_rdy), 64'd1);
    @(posedge clk); #1;
    send(32'd3, DW'(4), DW'(5), 1'b1, 1'b0, 1'b0);
    exp_q.push_back({DW'(5), 32'd41});
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("col_idx_lookup", 64'(col_idx_out), 64'd4);
        check("busy_in_flight", 64'(busy), 64'd1);
      end
      if (res_val) break;
    end
    check("accept_to_result_latency", 64'(lat), 64'd3);
    @(posedge clk); #1;
    wait_drain();

    // Output credits: 6 single-element rows with res_rdy low
    res_rdy = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 6) drive(DATA_W'(k + 1), DW'(k), DW'(20 + k), 1'b1, 1'b0);
      @(negedge clk);
      if (elem_rdy && k < 6) begin
        model_elem(DATA_W'(k + 1), DW'(k), DW'(20 + k), 1'b1, 1'b0);
        k++;
      end
      @(posedge clk); #1;
    end
    check("credit_accepted", 64'(k), 64'd4);
    @(negedge clk);
    check("credit_stall_rdy", 64'(elem_rdy), 64'd0);
    @(posedge clk); #1;
    res_rdy = 1'b1;
    for (int c = 0; c < 100 && k < 6; c++) begin
      drive(DATA_W'(k + 1), DW'(k), DW'(20 + k), 1'b1, 1'b0);
      @(negedge clk);
      if (elem_rdy) begin
        model_elem(DATA_W'(k + 1), DW'(k), DW'(20 + k), 1'b1, 1'b0);
        k++;
      end
      @(posedge clk); #1;
    end
    elem_val = 1'b0;
    check("credit_all_accepted", 64'(k), 64'd6);
    wait_drain();

    // Empty row 9 between rows 8 and 10
    send(32'd4, DW'(2), DW'(8), 1'b0, 1'b0);
    send(32'd5, DW'(3), DW'(8), 1'b1, 1'b0);
    send(32'd0, DW'(0), DW'(9), 1'b1, 1'b1);
    send(32'd6, DW'(5), DW'(10), 1'b1, 1'b0);
    wait_drain();

    // spmv_init with one result queued, one element accumulated, two in flight
    res_rdy = 1'b0;
    send(32'd7, DW'(6), DW'(30), 1'b1, 1'b0);
    lat = 0;
    while (!res_val && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("queued_before_init", 64'(res_val), 64'd1);
    @(posedge clk); #1;
    send(32'd1, DW'(1), DW'(31), 1'b0, 1'b0);
    send(32'd2, DW'(2), DW'(31), 1'b0, 1'b0);
    send(32'd5, DW'(3), DW'(31), 1'b0, 1'b0);
    spmv_init = 1'b1;
    @(posedge clk); #1;
    spmv_init = 1'b0;
    exp_q.delete();
    tb_acc = '0;
    @(negedge clk);
    check("init_res_val", 64'(res_val), 64'd0);
    check("init_busy", 64'(busy), 64'd0);
    check("init_res_data", 64'(res_data), 64'd0);
    check("init_col_idx", 64'(col_idx_out), 64'd0);
    @(posedge clk); #1;
    res_rdy = 1'b1;
    send(32'd3, DW'(3), DW'(32), 1'b1, 1'b0);
    wait_drain();

    // Large product: saturates with SPMV_MAC_SAT_EN, wraps to 0 without
    send(32'h40000000, DW'(7), DW'(40), 1'b1, 1'b0, 1'b0);
    exp_q.push_back({DW'(40), BIG_EXP});
    wait_drain();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
